// File: rtl/cpu6_ucode_pkg.sv
// cpu6_ucode_pkg: microword field positions, next-address op codes, sequencer S-select codes and controller states
package cpu6_ucode_pkg;
  localparam int OP_LSB   = 0;
  localparam int OP_W     = 4;
  localparam int CSEL_LSB = 4;
  localparam int CSEL_W   = 3;
  localparam int CPOL_BIT = 7;
  localparam int BR_LSB   = 8;
  localparam logic [3:0] OP_CONT  = 4'd0;
  localparam logic [3:0] OP_JMP   = 4'd1;
  localparam logic [3:0] OP_JMPC  = 4'd2;
  localparam logic [3:0] OP_CALL  = 4'd3;
  localparam logic [3:0] OP_CALLC = 4'd4;
  localparam logic [3:0] OP_RET   = 4'd5;
  localparam logic [3:0] OP_RETC  = 4'd6;
  localparam logic [3:0] OP_LDAR  = 4'd7;
  localparam logic [3:0] OP_JAR   = 4'd8;
  localparam logic [3:0] OP_JMAP  = 4'd9;
  localparam logic [3:0] OP_PUSH  = 4'd10;
  localparam logic [3:0] OP_LOOP  = 4'd11;
  localparam logic [3:0] OP_HALT  = 4'd12;
  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_AR  = 2'b01;
  localparam logic [1:0] SEL_STK = 2'b10;
  localparam logic [1:0] SEL_D   = 2'b11;
  typedef enum logic [1:0] {ST_START, ST_RUN, ST_HALTED} state_t;
endpackage

// File: rtl/ucode_stack_track.sv
// ucode_stack_track: shadow sequencer stack depth (0..DEPTH) from push/pop strobes, with sticky ovf/unf flags
module ucode_stack_track #(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  output logic ovf,
  output logic unf
);
  localparam int DW = $clog2(DEPTH + 1);
  logic [DW-1:0] depth;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (push) begin
        if (depth == DW'(DEPTH)) ovf <= 1'b1;
        else depth <= depth + DW'(1);
      end
      if (pop) begin
        if (depth == '0) unf <= 1'b1;
        else depth <= depth - DW'(1);
      end
    end
  end
endmodule

// File: rtl/ucode_seq_ctl.sv
// ucode_seq_ctl: latches control-store word at seq_y into upipe, decodes it into Am2909 controls (s/fe/pup/re/zero/cin/din/rin), replays on stall/halt, tracks stack depth
module ucode_seq_ctl
  import cpu6_ucode_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WORD_W      = 56,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] seq_y,
  input  logic [WORD_W-1:0] rom_data,
  input  logic [7:0]        cond_in,
  input  logic [ADDR_W-1:0] map_addr,
  input  logic              stall,
  output logic [WORD_W-1:0] upipe,
  output logic [1:0]        seq_s,
  output logic              seq_fe_n,
  output logic              seq_pup,
  output logic              seq_re_n,
  output logic              seq_zero_n,
  output logic              seq_cin,
  output logic [ADDR_W-1:0] seq_din,
  output logic [ADDR_W-1:0] seq_rin,
  output logic              halted,
  output logic              stk_ovf,
  output logic              stk_unf,
  output logic              illegal_op
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] uaddr_q, branch;
  logic [3:0] op;
  logic cond, run, replay, illegal;
  assign op      = upipe[OP_LSB +: OP_W];
  assign branch  = upipe[BR_LSB +: ADDR_W];
  assign cond    = cond_in[upipe[CSEL_LSB +: CSEL_W]] ^ upipe[CPOL_BIT];
  assign run     = state == ST_RUN && !stall;
  assign seq_cin = 1'b1;
  assign seq_rin = branch;
  always_comb begin
    state_nx   = state;
    seq_s      = SEL_PC;
    seq_fe_n   = 1'b1;
    seq_pup    = 1'b0;
    seq_re_n   = 1'b1;
    seq_zero_n = 1'b1;
    seq_din    = branch;
    illegal    = 1'b0;
    replay     = state == ST_HALTED || (state == ST_RUN && stall);
    if (state == ST_START) begin
      seq_zero_n = 1'b0;
      state_nx   = ST_RUN;
    end
    if (run) begin
      case (op)
        OP_CONT: ;
        OP_JMP:  seq_s = SEL_D;
        OP_JMPC: seq_s = cond ? SEL_D : SEL_PC;
        OP_CALL: {seq_s, seq_fe_n, seq_pup} = {SEL_D, 2'b01};
        OP_CALLC: {seq_s, seq_fe_n, seq_pup} = cond ? {SEL_D, 2'b01} : {SEL_PC, 2'b10};
        OP_RET:  {seq_s, seq_fe_n} = {SEL_STK, 1'b0};
        OP_RETC: {seq_s, seq_fe_n} = cond ? {SEL_STK, 1'b0} : {SEL_PC, 1'b1};
        OP_LDAR: seq_re_n = 1'b0;
        OP_JAR:  seq_s = SEL_AR;
        OP_JMAP: {seq_s, seq_din} = {SEL_D, map_addr};
        OP_PUSH: {seq_fe_n, seq_pup} = 2'b01;
        // false: jump to top of stack and keep it; true: pop and fall through
        OP_LOOP: {seq_s, seq_fe_n} = cond ? {SEL_PC, 1'b0} : {SEL_STK, 1'b1};
        OP_HALT: begin
          replay   = 1'b1;
          state_nx = ST_HALTED;
        end
        default: illegal = 1'b1;
      endcase
    end
    // re-emit the address of the word in upipe so the sequencer PC stays at uaddr_q+1
    if (replay) {seq_s, seq_din} = {SEL_D, uaddr_q};
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_START;
      upipe      <= '0;
      uaddr_q    <= '0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_nx;
      halted     <= state_nx == ST_HALTED;
      illegal_op <= illegal_op | illegal;
      if (!(state == ST_RUN && stall)) upipe <= rom_data;
      if (run) uaddr_q <= seq_y;
    end
  end
  ucode_stack_track #(.DEPTH(STACK_DEPTH)) u_stk (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (!seq_fe_n && seq_pup),
    .pop     (!seq_fe_n && !seq_pup),
    .ovf     (stk_ovf),
    .unf     (stk_unf)
  );
endmodule

// File: tb/tb_ucode_seq_ctl.sv
// tb_ucode_seq_ctl: random microprograms run through an Am2909 sequencer model, DUT checked each cycle against a table-driven reference
module tb_ucode_seq_ctl;
  localparam int AW = 12;
  localparam int WW = 56;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [AW-1:0] seq_y, map_addr, seq_din, seq_rin;
  logic [WW-1:0] rom_data, upipe;
  logic [7:0] cond_in;
  logic stall, seq_fe_n, seq_pup, seq_re_n, seq_zero_n, seq_cin;
  logic halted, stk_ovf, stk_unf, illegal_op;
  logic [1:0] seq_s;
  logic [WW-1:0] rom [0:(1<<AW)-1];
  logic [AW-1:0] pc = '0, ar = '0;
  logic [AW-1:0] stk [0:3] = '{default: '0};
  logic [1:0] sp = '0;
  int n_cmp = 0, n_bad = 0;
  int phase;
  logic [WW-1:0] m_up;
  logic [AW-1:0] m_ua;
  int m_depth;
  bit m_ovf, m_unf, m_ill;
  logic [3:0] tk [16] = '{4'b0010, 4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1000, 4'b1000, 4'b0010,
                          4'b0110, 4'b1110, 4'b0001, 4'b0000, 4'b1110, 4'b0010, 4'b0010, 4'b0010};
  logic [3:0] nt [16] = '{4'b0010, 4'b1110, 4'b0010, 4'b1101, 4'b0010, 4'b1000, 4'b0010, 4'b0010,
                          4'b0110, 4'b1110, 4'b0001, 4'b1010, 4'b1110, 4'b0010, 4'b0010, 4'b0010};
  always #5 clock = ~clock;
  ucode_seq_ctl #(.ADDR_W(AW), .WORD_W(WW), .STACK_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .seq_y(seq_y), .rom_data(rom_data), .cond_in(cond_in),
    .map_addr(map_addr), .stall(stall), .upipe(upipe), .seq_s(seq_s), .seq_fe_n(seq_fe_n),
    .seq_pup(seq_pup), .seq_re_n(seq_re_n), .seq_zero_n(seq_zero_n), .seq_cin(seq_cin),
    .seq_din(seq_din), .seq_rin(seq_rin), .halted(halted), .stk_ovf(stk_ovf),
    .stk_unf(stk_unf), .illegal_op(illegal_op)
  );
  always_comb begin
    seq_y = !seq_zero_n ? '0 : seq_s == 2'd0 ? pc : seq_s == 2'd1 ? ar : seq_s == 2'd2 ? stk[sp] : seq_din;
    rom_data = rom[seq_y];
  end
  always @(posedge clock) begin
    pc <= seq_y + AW'(seq_cin);
    if (!seq_re_n) ar <= seq_rin;
    if (!seq_fe_n && seq_pup) begin
      sp <= sp + 2'd1;
      stk[sp + 2'd1] <= pc;
    end
    if (!seq_fe_n && !seq_pup) sp <= sp - 2'd1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [WW-1:0] mk(input int op, input int br);
    return {36'({$urandom, $urandom}), 12'(br), 1'($urandom), 3'($urandom), 4'(op)};
  endfunction
  function automatic int rnd_op();
    int o = $urandom_range(15);
    return o == 12 ? 0 : o;
  endfunction
  task automatic check_cycle();
    logic [3:0] c, op;
    logic re_e, zero_e, cnd;
    logic [AW-1:0] din_e, br;
    bit replay;
    op = m_up[3:0];
    br = m_up[19:8];
    cnd = cond_in[m_up[6:4]] ^ m_up[7];
    replay = phase == 2 || (phase == 1 && (stall || op == 4'd12));
    c = 4'b0010;
    re_e = 1'b1;
    zero_e = 1'b1;
    din_e = br;
    if (phase == 0) zero_e = 1'b0;
    else if (replay) begin
      c = 4'b1110;
      din_e = m_ua;
    end else begin
      c = cnd ? tk[op] : nt[op];
      re_e = op != 4'd7;
      if (op == 4'd9) din_e = map_addr;
    end
    chk("ctl", {seq_s, seq_fe_n, seq_pup, seq_re_n, seq_zero_n, seq_cin}, {c, re_e, zero_e, 1'b1});
    chk("din", seq_din, din_e);
    chk("rin", seq_rin, br);
    chk("upipe", upipe, m_up);
    chk("flags", {halted, stk_ovf, stk_unf, illegal_op}, {phase == 2, m_ovf, m_unf, m_ill});
    chk("depth", 64'(dut.u_stk.depth), 64'(m_depth));
    if (phase == 0) begin
      m_up = rom[seq_y];
      phase = 1;
    end else if (phase == 2) m_up = rom[seq_y];
    else if (!stall) begin
      if (!c[1] && c[0]) begin
        if (m_depth == 4) m_ovf = 1;
        else m_depth++;
      end
      if (!c[1] && !c[0]) begin
        if (m_depth == 0) m_unf = 1;
        else m_depth--;
      end
      if (op >= 4'd13) m_ill = 1;
      m_up = rom[seq_y];
      m_ua = seq_y;
      if (op == 4'd12) phase = 2;
    end
  endtask
  task automatic step(input int stall_pct);
    cond_in = 8'($urandom);
    map_addr = AW'($urandom);
    stall = $urandom_range(99) < stall_pct;
    #1 check_cycle();
    @(negedge clock);
  endtask
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_upipe", upipe, '0);
    chk("rst_flags", {halted, stk_ovf, stk_unf, illegal_op}, 4'b0);
    chk("rst_zero", seq_zero_n, 1'b0);
    chk("rst_depth", 64'(dut.u_stk.depth), 64'd0);
    phase = 0;
    m_up = '0;
    m_ua = '0;
    m_depth = 0;
    {m_ovf, m_unf, m_ill} = 3'b0;
    stall = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask
  task automatic fill_random();
    for (int i = 0; i < (1 << AW); i++) rom[i] = mk(rnd_op(), $urandom);
  endtask
  initial begin
    stall = 1'b0;
    cond_in = '0;
    map_addr = '0;
    for (int i = 0; i < (1 << AW); i++) rom[i] = mk(3, i + 1);
    do_reset();
    repeat (8) step(0);
    chk("ovf_seen", stk_ovf, 1'b1);
    for (int i = 0; i < (1 << AW); i++) rom[i] = mk(5, $urandom);
    do_reset();
    repeat (4) step(0);
    chk("unf_seen", stk_unf, 1'b1);
    for (int i = 0; i < (1 << AW); i++) rom[i] = mk(10, $urandom);
    do_reset();
    repeat (30) step(50);
    repeat (6) begin
      fill_random();
      do_reset();
      repeat (300) step(20);
    end
    fill_random();
    rom[0] = mk(0, $urandom);
    rom[1] = mk(1, 5);
    rom[5] = mk(12, $urandom);
    do_reset();
    repeat (10) step(30);
    chk("halted", halted, 1'b1);
    do_reset();
    repeat (5) step(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
